datamem_sync: RTL and testbench
===============================

Name: datamem_sync

Overview:
- Parametrised, clocked successor to the CPU data memory, sitting between the MEM stage and the word array.
- Byte-addressed, little-endian storage with byte/half/word loads and stores, including sign or zero extension on loads.
- Valid/ready request handshake with configurable response latency.
- Misaligned, out-of-range and illegal-size accesses return an error instead of corrupting memory.

Parameters:
- ADDR_W, 9, word-index width; depth = 2**ADDR_W 32-bit words (default 512)
- LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present this cycle
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  input  1  loads only: 1 = zero-extend (lbu/lhu), 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle pulse, response present
- resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors
- resp_err  output  1  qualifies resp_valid: access rejected

Behaviour:
- Reset (while reset=1 at a clock edge):
  - state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - req_ready=0 while reset is high; 1 in the first cycle after reset deasserts.
  - Memory array is not cleared.
- Accept: a request is accepted on an edge where req_valid && req_ready.
- States:
  - IDLE: req_ready=1. Accept -> WAIT if LATENCY>1, else -> RESP.
  - WAIT: req_ready=0. Counter counts up to LATENCY-1, then -> RESP.
  - RESP: resp_valid=1, req_ready=1. Accept in the same cycle -> WAIT/RESP as from IDLE; otherwise -> IDLE.
- Latency and throughput:
  - A request accepted at edge N yields resp_valid high during cycle N+LATENCY, exactly one cycle.
  - LATENCY=1 gives one request per cycle sustained.
  - LATENCY>1 gives one request per LATENCY cycles.
- No response backpressure: the consumer must take resp_valid when it pulses.
- Error check, evaluated at accept:
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (addr[31:ADDR_W+2] != 0).
  - On error: no memory write; response is resp_err=1, resp_rdata=0.
- Word index = addr[ADDR_W+1:2]; byte lane = addr[1:0].
- Stores (no error): update only the addressed lanes, at the accept edge.
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} <= wdata[15:0]; low byte goes to the lower address.
  - Word: all four lanes.
  - resp_rdata=0, resp_err=0.
- Loads (no error): the array is read at the accept edge and the extracted, extended value is registered.
  - Selected data is held unchanged through WAIT and presented in RESP.
  - Byte: lane value, bit 7 replicated when req_unsigned=0.
  - Half: bit 15 replicated when req_unsigned=0.
  - Word: unmodified.
- resp_rdata and resp_err hold their last values when resp_valid=0. Consumers ignore them then.
- Back-to-back store then load to the same word (LATENCY=1): the load sees the stored data, because the store has committed at the earlier edge.
- Reset mid-operation:
  - Any pending response is discarded; no resp_valid follows.
  - A store already accepted stays committed.
- Accesses are in-order; only one request is outstanding at a time.

Test Plan:
- LATENCY=1: sw 0x8badf00d @0x10, then lw @0x10, lb @0x13, lbu @0x13, lh @0x10, lhu @0x12 on consecutive cycles -> resp_rdata 0x8badf00d, 0xffffff8b, 0x0000008b, 0xfffff00d, 0x00008bad. resp_valid high 5 consecutive cycles after the sw response; resp_err=0 throughout.
- sw 0x11223344 @0x20, sb 0xaa @0x21, sh 0xbeef @0x22, lw @0x20 -> 0xbeefaa44.
- Errors: lh @0x31, lw @0x32, size=11 @0x30, sw @0x800 (ADDR_W=9) -> each gives resp_err=1, resp_rdata=0. A following lw @0x30 returns the prior contents unchanged.
- LATENCY=4: accept lw at edge N -> req_ready low cycles N+1..N+3, resp_valid only in cycle N+4. A new request presented at N+2 is held until accepted at the N+4 edge.
- Reset asserted one cycle after accepting a load (LATENCY=3) -> no resp_valid. Outputs are 0 and req_ready=0 during reset; req_ready=1 the cycle after release.
- Reset asserted one cycle after accepting a store (LATENCY=3) -> no resp_valid, but a subsequent lw returns the stored value.

Source files
------------

// File: rtl/datamem_sync.sv
// Clocked byte-addressed little-endian data memory with a valid/ready request port and fixed response latency.
// Misaligned, out-of-range and illegal-size accesses are rejected with resp_err and never touch the array.
module datamem_sync #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic              r_resp_err;
   logic [31:0]       r_mem [DEPTH];

   logic              w_accept;
   logic              w_oor;
   logic              w_err;
   logic              w_store;
   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_lane;
   logic [31:0]       w_word;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load;
   logic [3:0]        w_be;
   logic [31:0]       w_wlanes;

   // Ready drops combinationally with reset so nothing can be accepted while it is held.
   assign req_ready  = ~reset & (r_state != WAIT);
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;

   assign w_accept = req_valid & req_ready;
   assign w_idx    = req_addr[ADDR_W+1:2];
   assign w_lane   = req_addr[1:0];
   assign w_oor    = (req_addr >> (ADDR_W + 2)) != 32'd0;
   assign w_err    = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                   | w_oor;
   assign w_store  = w_accept & req_write & ~w_err;

   // Load lane extraction and sign/zero extension.
   always_comb begin
      w_word = r_mem[w_idx];
      w_byte = w_word[7:0];
      w_half = w_word[15:0];
      w_load = w_word;
      case (w_lane)
         2'd1:    w_byte = w_word[15:8];
         2'd2:    w_byte = w_word[23:16];
         2'd3:    w_byte = w_word[31:24];
         default: w_byte = w_word[7:0];
      endcase
      if (req_addr[1]) w_half = w_word[31:16];
      case (req_size)
         2'b00:   w_load = req_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = req_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = w_word;
      endcase
   end

   // Store byte enables with right-justified data replicated onto every lane.
   always_comb begin
      w_be     = 4'b1111;
      w_wlanes = req_wdata;
      case (req_size)
         2'b00: begin
            w_be     = 4'b0001 << w_lane;
            w_wlanes = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_be     = req_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{req_wdata[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wlanes = req_wdata;
         end
      endcase
   end

   // Array is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_store) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            IDLE, RESP: begin
               if (w_accept) begin
                  r_resp_rdata <= (w_err | req_write) ? 32'd0 : w_load;
                  r_resp_err   <= w_err;
                  if (LATENCY > 1) begin
                     r_state <= WAIT;
                     r_cnt   <= CNT_W'(1);
                  end else begin
                     r_state      <= RESP;
                     r_resp_valid <= 1'b1;
                  end
               end else begin
                  r_state <= IDLE;
               end
            end
            WAIT: begin
               if (r_cnt == CNT_LAST) begin
                  r_state      <= RESP;
                  r_resp_valid <= 1'b1;
                  r_cnt        <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_datamem_sync.sv
// Scoreboard bench for datamem_sync: three instances (latency 1, 4, 3) share request inputs, one is selected per request.
// Expected responses carry the cycle they are due in; a negedge monitor pops and compares them.
module tb_datamem_sync;
   typedef struct {
      int          dut;
      int          due;
      logic [31:0] rd;
      logic        err;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   int          sel;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  w_valid;
   logic [2:0]  w_ready;
   logic [2:0]  w_rv;
   logic [2:0]  w_err;
   logic [31:0] w_rd [3];

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   assign w_valid = req_valid ? (3'b001 << sel) : 3'b000;

   datamem_sync #(.ADDR_W(9), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .req_valid(w_valid[0]), .req_ready(w_ready[0]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(w_rv[0]), .resp_rdata(w_rd[0]), .resp_err(w_err[0]));

   datamem_sync #(.ADDR_W(9), .LATENCY(4)) u_l4 (
      .clk(clk), .reset(reset), .req_valid(w_valid[1]), .req_ready(w_ready[1]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(w_rv[1]), .resp_rdata(w_rd[1]), .resp_err(w_err[1]));

   datamem_sync #(.ADDR_W(9), .LATENCY(3)) u_l3 (
      .clk(clk), .reset(reset), .req_valid(w_valid[2]), .req_ready(w_ready[2]),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(w_rv[2]), .resp_rdata(w_rd[2]), .resp_err(w_err[2]));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat(input int d);
      case (d)
         0:       return 1;
         1:       return 4;
         default: return 3;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: any resp_valid must match the head entry's instance and due cycle.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 3; d++) begin
         if (w_rv[d] === 1'b1) begin
            if (exp_q.size() == 0 || exp_q[0].dut != d || exp_q[0].due != cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_resp dut%0d: resp_valid=1 at cycle %0d, required 0", d, cyc);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, " rdata"}, w_rd[d], e.rd);
               chk({e.name, " err"}, 32'(w_err[d]), 32'(e.err));
            end
         end
      end
      if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s missing_resp: resp_valid=0 at cycle %0d, required 1", exp_q[0].name, exp_q[0].due);
         void'(exp_q.pop_front());
      end
   end

   // Present a request at a negedge, wait for ready, record the expectation, return at the next negedge.
   task automatic issue(input int d, input string name, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input bit expect_resp);
      int   k;
      exp_t e;
      sel          = d;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      req_valid    = 1'b1;
      k = 0;
      while (w_ready[d] !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (w_ready[d] !== 1'b1) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s accept_timeout: req_ready=%b after %0d cycles, required 1", name, w_ready[d], k);
         req_valid = 1'b0;
         return;
      end
      if (expect_resp) begin
         e.dut  = d;
         e.due  = cyc + lat(d);
         e.rd   = exp_rd;
         e.err  = exp_err;
         e.name = name;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      reset = 1'b1; req_valid = 1'b0; sel = 0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst dut%0d ready", d), 32'(w_ready[d]), 32'd0);
         chk($sformatf("rst dut%0d valid", d), 32'(w_rv[d]), 32'd0);
         chk($sformatf("rst dut%0d rdata", d), w_rd[d], 32'd0);
         chk($sformatf("rst dut%0d err", d), 32'(w_err[d]), 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("post_rst dut%0d ready", d), 32'(w_ready[d]), 32'd1);
      @(negedge clk);

      // Latency 1: back-to-back loads of every width after one store.
      issue(0, "sw10",  1'b1, 2'b10, 1'b0, 32'h10, 32'h8badf00d, 32'h0,        1'b0, 1'b1);
      issue(0, "lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h8badf00d, 1'b0, 1'b1);
      issue(0, "lb13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hffffff8b, 1'b0, 1'b1);
      issue(0, "lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h0000008b, 1'b0, 1'b1);
      issue(0, "lh10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hfffff00d, 1'b0, 1'b1);
      issue(0, "lhu12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00008bad, 1'b0, 1'b1);

      // Partial stores merge into the word; upper store-data bits must be ignored.
      issue(0, "sw20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 32'h0,        1'b0, 1'b1);
      issue(0, "sb21",  1'b1, 2'b00, 1'b0, 32'h21, 32'h123456aa, 32'h0,        1'b0, 1'b1);
      issue(0, "sh22",  1'b1, 2'b01, 1'b0, 32'h22, 32'h9876beef, 32'h0,        1'b0, 1'b1);
      issue(0, "lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hbeefaa44, 1'b0, 1'b1);
      issue(0, "lb21",  1'b0, 2'b00, 1'b0, 32'h21, 32'h0,        32'hffffffaa, 1'b0, 1'b1);
      issue(0, "lhu20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        32'h0000aa44, 1'b0, 1'b1);
      issue(0, "lh22",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        32'hffffbeef, 1'b0, 1'b1);
      issue(0, "lbu23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0,        32'h000000be, 1'b0, 1'b1);

      // Rejected accesses: no write, err=1, rdata=0.
      issue(0, "sw30",    1'b1, 2'b10, 1'b0, 32'h30,      32'h01020304, 32'h0,        1'b0, 1'b1);
      issue(0, "sw00",    1'b1, 2'b10, 1'b0, 32'h00,      32'h55aa55aa, 32'h0,        1'b0, 1'b1);
      issue(0, "lh31",    1'b0, 2'b01, 1'b0, 32'h31,      32'h0,        32'h0,        1'b1, 1'b1);
      issue(0, "lw32",    1'b0, 2'b10, 1'b0, 32'h32,      32'h0,        32'h0,        1'b1, 1'b1);
      issue(0, "sz11_30", 1'b1, 2'b11, 1'b0, 32'h30,      32'hdeadbeef, 32'h0,        1'b1, 1'b1);
      issue(0, "sw800",   1'b1, 2'b10, 1'b0, 32'h800,     32'hdeadbeef, 32'h0,        1'b1, 1'b1);
      issue(0, "sb_hi",   1'b1, 2'b00, 1'b0, 32'h1000030, 32'hdeadbeef, 32'h0,        1'b1, 1'b1);
      issue(0, "lw30",    1'b0, 2'b10, 1'b0, 32'h30,      32'h0,        32'h01020304, 1'b0, 1'b1);
      issue(0, "lw00",    1'b0, 2'b10, 1'b0, 32'h00,      32'h0,        32'h55aa55aa, 1'b0, 1'b1);
      issue(0, "sw7fc",   1'b1, 2'b10, 1'b0, 32'h7fc,     32'ha5a50f0f, 32'h0,        1'b0, 1'b1);
      issue(0, "lw7fc",   1'b0, 2'b10, 1'b0, 32'h7fc,     32'h0,        32'ha5a50f0f, 1'b0, 1'b1);
      repeat (3) @(negedge clk);

      // Latency 4: ready low for three cycles, a held request is accepted on the response edge.
      issue(1, "l4 sw50", 1'b1, 2'b10, 1'b0, 32'h50, 32'h12345678, 32'h0, 1'b0, 1'b1);
      issue(1, "l4 lw50", 1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 32'h12345678, 1'b0, 1'b1);
      chk("l4 ready N+1", 32'(w_ready[1]), 32'd0);
      @(negedge clk);
      chk("l4 ready N+2", 32'(w_ready[1]), 32'd0);
      sel = 1; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h53; req_valid = 1'b1;
      @(negedge clk);
      chk("l4 ready N+3", 32'(w_ready[1]), 32'd0);
      @(negedge clk);
      chk("l4 ready N+4", 32'(w_ready[1]), 32'd1);
      issue(1, "l4 lbu53", 1'b0, 2'b00, 1'b1, 32'h53, 32'h0, 32'h00000012, 1'b0, 1'b1);
      repeat (6) @(negedge clk);

      // Latency 3: reset one cycle after a load discards its response.
      issue(2, "l3 sw60", 1'b1, 2'b10, 1'b0, 32'h60, 32'h0badcafe, 32'h0, 1'b0, 1'b1);
      issue(2, "l3 lw60", 1'b0, 2'b10, 1'b0, 32'h60, 32'h0, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("l3 rst ready", 32'(w_ready[2]), 32'd0);
      chk("l3 rst valid", 32'(w_rv[2]), 32'd0);
      chk("l3 rst rdata", w_rd[2], 32'd0);
      chk("l3 rst err", 32'(w_err[2]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("l3 release ready", 32'(w_ready[2]), 32'd1);
      repeat (5) @(negedge clk);

      // Latency 3: reset one cycle after a store keeps the store.
      issue(2, "l3 sw70", 1'b1, 2'b10, 1'b0, 32'h70, 32'hfeedface, 32'h0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("l3 rst2 valid", 32'(w_rv[2]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      issue(2, "l3 lw70", 1'b0, 2'b10, 1'b0, 32'h70, 32'h0, 32'hfeedface, 1'b0, 1'b1);

      k = 0;
      while (exp_q.size() > 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      while (exp_q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s drain_timeout: response never seen, required one", exp_q[0].name);
         void'(exp_q.pop_front());
      end
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
